// File: rtl/prog_cfg_pkg.sv
// Shared configuration helpers for the programmable connection box.
// Select-field width, frame length and the disabled-select encoding live here.
package prog_cfg_pkg;

    // Width needed to encode 'value' distinct codes (ceil(log2(value))).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // One extra code beyond the track count is reserved for "output disabled".
    function automatic int sel_width(input int inputs);
        return clog2(inputs + 1);
    endfunction

    function automatic int frame_len(input int outputs, input int inputs);
        return outputs * sel_width(inputs);
    endfunction

    // Canonical disabled-select code; any select >= INPUTS also disables.
    function automatic int sel_disabled(input int inputs);
        return inputs;
    endfunction

    typedef enum logic [1:0] {
        CMT_NONE   = 2'd0,
        CMT_ACCEPT = 2'd1,
        CMT_REJECT = 2'd2
    } commit_e;

endpackage

// File: rtl/prog_mux_cell.sv
// One routed output: selects a track by its configured select field, or drives 0
// when the select is out of range or the configuration is not yet valid.
module prog_mux_cell
    import prog_cfg_pkg::*;
#(
    parameter int INPUTS = 16,
    parameter int SEL_W  = 5
) (
    input  logic [INPUTS-1:0] in,
    input  logic [SEL_W-1:0]  sel,
    input  logic              en,
    output logic              out
);

    localparam int EXT_W = 1 << SEL_W;
    localparam logic [SEL_W-1:0] SEL_OFF = SEL_W'(sel_disabled(INPUTS));

    // Zero-padding the tracks to the full select range keeps every index legal.
    logic [EXT_W-1:0] in_ext;
    logic             sel_hit;

    assign in_ext  = {{(EXT_W - INPUTS){1'b0}}, in};
    assign sel_hit = (sel < SEL_OFF);
    assign out     = en & sel_hit & in_ext[sel];

endmodule

// File: rtl/prog_conn_box.sv
// Programmable connection box: serial configuration chain with a shadow/active
// double buffer, frame-length checked commit, and per-output track selection.
module prog_conn_box
    import prog_cfg_pkg::*;
#(
    parameter int INPUTS  = 16,
    parameter int OUTPUTS = 20
) (
    input  logic               prog_clk,
    input  logic               prog_rst_n,
    input  logic               prog_en,
    input  logic               prog_in,
    input  logic               prog_commit,
    input  logic [INPUTS-1:0]  in,
    output logic               prog_out,
    output logic [OUTPUTS-1:0] out,
    output logic               cfg_valid,
    output logic               cfg_err
);

    localparam int SEL_W = sel_width(INPUTS);
    localparam int FRAME = frame_len(OUTPUTS, INPUTS);
    localparam int CNT_W = clog2(FRAME + 2);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [FRAME-1:0] shadow_q, shadow_d;
    logic [FRAME-1:0] active_q, active_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             valid_q,  valid_d;
    logic             err_q,    err_d;
    commit_e          commit_kind;

    // Classify the commit request; a commit racing a shift is always rejected.
    always_comb begin
        commit_kind = CMT_NONE;
        if (prog_commit) begin
            if (!prog_en && (cnt_q == CNT_FULL)) begin
                commit_kind = CMT_ACCEPT;
            end else begin
                commit_kind = CMT_REJECT;
            end
        end
    end

    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        err_d    = err_q;

        if (prog_en) begin
            shadow_d = {shadow_q[FRAME-2:0], prog_in};
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        case (commit_kind)
            CMT_ACCEPT: begin
                active_d = shadow_q;
                valid_d  = 1'b1;
                err_d    = 1'b0;
                cnt_d    = '0;
            end
            CMT_REJECT: begin
                err_d = 1'b1;
                // The coincident shift is the first bit of the next frame.
                cnt_d = prog_en ? CNT_ONE : '0;
            end
            default: ;
        endcase
    end

    // NOTE: the configuration registers are plain flops, so they take the async reset like any other state.
    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign prog_out  = shadow_q[FRAME-1];
    assign cfg_valid = valid_q;
    assign cfg_err   = err_q;

    for (genvar k = 0; k < OUTPUTS; k++) begin : g_out
        prog_mux_cell #(
            .INPUTS (INPUTS),
            .SEL_W  (SEL_W)
        ) u_cell (
            .in  (in),
            .sel (active_q[k*SEL_W +: SEL_W]),
            .en  (valid_q),
            .out (out[k])
        );
    end

endmodule

// File: tb/tb_prog_conn_box.sv
// Directed bench for prog_conn_box at INPUTS=16, OUTPUTS=20 (SEL_W=5, FRAME=100).
module tb_prog_conn_box;

    localparam int INPUTS  = 16;
    localparam int OUTPUTS = 20;
    localparam int SEL_W   = 5;
    localparam int FRAME   = 100;

    logic               prog_clk;
    logic               prog_rst_n;
    logic               prog_en;
    logic               prog_in;
    logic               prog_commit;
    logic [INPUTS-1:0]  in;
    logic               prog_out;
    logic [OUTPUTS-1:0] out;
    logic               cfg_valid;
    logic               cfg_err;

    prog_conn_box #(
        .INPUTS  (INPUTS),
        .OUTPUTS (OUTPUTS)
    ) dut (
        .prog_clk    (prog_clk),
        .prog_rst_n  (prog_rst_n),
        .prog_en     (prog_en),
        .prog_in     (prog_in),
        .prog_commit (prog_commit),
        .in          (in),
        .prog_out    (prog_out),
        .out         (out),
        .cfg_valid   (cfg_valid),
        .cfg_err     (cfg_err)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [15:0] in_v;
        logic [19:0] out_a;
        logic [19:0] out_b;
    } vec_t;

    vec_t table_v [6];

    logic [FRAME-1:0] frame_a;
    logic [FRAME-1:0] frame_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Apply inputs for one clock edge, then return 1 time unit after it.
    task automatic cycle(input logic en, input logic din, input logic cmt);
        prog_en     = en;
        prog_in     = din;
        prog_commit = cmt;
        @(posedge prog_clk);
        #1;
        prog_en     = 1'b0;
        prog_in     = 1'b0;
        prog_commit = 1'b0;
    endtask

    // Shift n bits, MSB of the frame first; n beyond FRAME wraps the pattern.
    task automatic shift_bits(input logic [FRAME-1:0] vec, input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, vec[FRAME-1 - (i % FRAME)], 1'b0);
        end
    endtask

    task automatic commit();
        cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic run_table(input string name, input bit use_b);
        for (int i = 0; i < 6; i++) begin
            in = table_v[i].in_v;
            #1;
            check(name, 32'(out), 32'(use_b ? table_v[i].out_b : table_v[i].out_a));
        end
    endtask

    initial begin
        int errs;
        tests_run    = 0;
        tests_failed = 0;

        // Config A: sel_k = k for k<16, disabled (16) for k=16..19.
        // Config B: sel_k = 15-k for k<16, k-16 for k=16..19.
        for (int k = 0; k < OUTPUTS; k++) begin
            frame_a[k*SEL_W +: SEL_W] = (k < 16) ? 5'(k) : 5'd16;
            frame_b[k*SEL_W +: SEL_W] = (k < 16) ? 5'(15 - k) : 5'(k - 16);
        end

        table_v[0] = '{16'hA5C3, 20'h0A5C3, 20'h3C3A5};
        table_v[1] = '{16'hFFFF, 20'h0FFFF, 20'hFFFFF};
        table_v[2] = '{16'h0000, 20'h00000, 20'h00000};
        table_v[3] = '{16'h0001, 20'h00001, 20'h18000};
        table_v[4] = '{16'h00F0, 20'h000F0, 20'h00F00};
        table_v[5] = '{16'h1234, 20'h01234, 20'h42C48};

        prog_rst_n  = 1'b0;
        prog_en     = 1'b0;
        prog_in     = 1'b0;
        prog_commit = 1'b0;
        in          = 16'hFFFF;
        #12;
        prog_rst_n  = 1'b1;
        @(posedge prog_clk);
        #1;

        check("reset_cfg_valid", 32'(cfg_valid), 32'd0);
        check("reset_cfg_err",   32'(cfg_err),   32'd0);
        check("reset_prog_out",  32'(prog_out),  32'd0);
        check("reset_out",       32'(out),       32'd0);

        // Full frame A, then commit.
        shift_bits(frame_a, FRAME);
        check("precommit_out", 32'(out), 32'd0);
        commit();
        check("commit_a_valid", 32'(cfg_valid), 32'd1);
        check("commit_a_err",   32'(cfg_err),   32'd0);
        run_table("cfg_a_out", 1'b0);

        // Short frame rejected; error is sticky; long frame rejected too.
        shift_bits(frame_b, FRAME - 1);
        commit();
        check("short_err", 32'(cfg_err), 32'd1);
        in = 16'hA5C3;
        #1;
        check("short_out_kept", 32'(out), 32'h0A5C3);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0);
        check("err_sticky", 32'(cfg_err), 32'd1);
        shift_bits(frame_b, FRAME + 1);
        commit();
        check("long_err", 32'(cfg_err), 32'd1);
        check("long_valid", 32'(cfg_valid), 32'd1);
        run_table("long_out_kept", 1'b0);

        // Shifting B must not disturb outputs driven by A.
        errs = 0;
        for (int i = 0; i < FRAME; i++) begin
            in = 16'($urandom);
            cycle(1'b1, frame_b[FRAME-1-i], 1'b0);
            if (out !== {4'h0, in}) errs++;
        end
        check("shift_out_stable", 32'(errs), 32'd0);
        commit();
        check("commit_b_err", 32'(cfg_err), 32'd0);
        run_table("cfg_b_out", 1'b1);

        // prog_out replays frame A while a second frame pushes it through.
        shift_bits(frame_a, FRAME);
        errs = 0;
        for (int j = 0; j < FRAME; j++) begin
            if (prog_out !== frame_a[FRAME-1-j]) errs++;
            cycle(1'b1, frame_b[FRAME-1-j], 1'b0);
        end
        check("prog_out_replay", 32'(errs), 32'd0);
        commit();
        check("overshoot_err", 32'(cfg_err), 32'd1);
        run_table("overshoot_out_kept", 1'b1);

        // Commit on the 100th shift: rejected, and that bit starts a new frame.
        shift_bits('0, FRAME - 1);
        cycle(1'b1, frame_a[FRAME-1], 1'b1);
        check("race_err", 32'(cfg_err), 32'd1);
        run_table("race_out_kept", 1'b1);
        for (int i = 1; i < FRAME; i++) cycle(1'b1, frame_a[FRAME-1-i], 1'b0);
        commit();
        check("race_recover_err", 32'(cfg_err), 32'd0);
        run_table("race_recover_out", 1'b0);

        // Asynchronous reset mid-frame.
        shift_bits(frame_b, 50);
        in = 16'hFFFF;
        #2;
        prog_rst_n = 1'b0;
        #1;
        check("midrst_out",      32'(out),       32'd0);
        check("midrst_valid",    32'(cfg_valid), 32'd0);
        check("midrst_prog_out", 32'(prog_out),  32'd0);
        check("midrst_err",      32'(cfg_err),   32'd0);
        #2;
        prog_rst_n = 1'b1;
        @(posedge prog_clk);
        #1;
        commit();
        check("postrst_empty_err",   32'(cfg_err),   32'd1);
        check("postrst_empty_valid", 32'(cfg_valid), 32'd0);
        shift_bits(frame_b, FRAME);
        commit();
        check("postrst_valid", 32'(cfg_valid), 32'd1);
        check("postrst_err",   32'(cfg_err),   32'd0);
        run_table("postrst_out", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/prog_conn_box.md
PROG_CONN_BOX -- requirements
Module: prog_conn_box

Interface
REQ-001 The module SHALL have parameter INPUTS, default 16, giving the number of routable input tracks (range 2..256).
REQ-002 The module SHALL have parameter OUTPUTS, default 20, giving the number of routed output pins (range 1..256).
REQ-003 The module SHALL derive localparams SEL_W = clog2(INPUTS+1) and FRAME = OUTPUTS*SEL_W, which are not user-overridable.
REQ-004 The module SHALL have one clock and an asynchronous, active-low reset, with the ports listed as follows.
- prog_clk  in  1  single clock; all state on its rising edge
- prog_rst_n  in  1  asynchronous active-low reset
- prog_en  in  1  shift-enable for the configuration chain
- prog_in  in  1  serial configuration data in
- prog_commit  in  1  one-cycle request to load shadow into active config
- in  in  INPUTS  routable tracks
- prog_out  out  1  serial chain out, for daisy-chaining and readback
- out  out  OUTPUTS  routed outputs
- cfg_valid  out  1  active configuration has been committed since reset
- cfg_err  out  1  last commit rejected (bad frame length or protocol)

Function
REQ-005 The block SHALL hold a FRAME-bit shadow shift register.
- While prog_en=1, each cycle: shadow[0]<=prog_in and shadow[i]<=shadow[i-1].
- While prog_en=0, shadow holds.
REQ-006 prog_out SHALL equal shadow[FRAME-1] (registered), so a bit entering at prog_in appears at prog_out FRAME cycles of prog_en later.
REQ-007 Output k's shadow select field SHALL be shadow[k*SEL_W +: SEL_W]; the first bit shifted in of a frame lands in the MSB of output OUTPUTS-1.
REQ-008 A bit counter SHALL increment per prog_en cycle, saturating at FRAME+1 so that overshoot is detectable.
REQ-009 On prog_commit=1 with prog_en=0 and counter==FRAME, the block SHALL on the same edge:
- copy shadow into the FRAME-bit active register;
- set cfg_valid=1 and cfg_err=0;
- clear the counter.
REQ-010 On prog_commit=1 with counter!=FRAME (short or long frame), the block SHALL leave the active register unchanged, set cfg_err=1, and clear the counter.
REQ-011 On prog_commit=1 coincident with prog_en=1, the shift SHALL occur, the commit SHALL be rejected as in REQ-010, and the counter SHALL restart at 1.
REQ-012 out[k] SHALL be combinational from the active register: in[sel_k] when sel_k<INPUTS, else 0 (output disabled).
REQ-013 Shifting SHALL never disturb out; out changes only on the cycle following an accepted commit.
REQ-014 cfg_err SHALL remain set until the next accepted commit or reset.

Reset
REQ-015 Assertion of prog_rst_n=0 SHALL immediately clear shadow, active register, counter, prog_out, cfg_valid and cfg_err, so every out bit reads 0 (select 0 is disabled only by cfg_valid gating; see REQ-016).
REQ-016 While cfg_valid=0, out SHALL be forced to all zeros regardless of the active register contents.
REQ-017 Reset asserted mid-frame SHALL discard the partial frame; a full new frame is then required.

Structure
REQ-018 A shared package prog_cfg_pkg SHALL hold the clog2 function, the SEL_W/FRAME derivation, and the disabled-select encoding constant.
REQ-019 The per-output selection logic SHALL be one sub-module prog_mux_cell (parameters INPUTS, SEL_W), instantiated OUTPUTS times via generate.
REQ-020 The shift register, counter and commit logic SHALL reside in prog_conn_box itself.

Verification (INPUTS=16, OUTPUTS=20, SEL_W=5, FRAME=100)
REQ-021 Shift 100 bits setting output k select = k mod 16 (k=16..19: 16 = disabled), then commit -> cfg_valid=1, out[k]=in[k mod 16] for k<16, out[16..19]=0.
REQ-022 Shift 99 bits then commit -> cfg_err=1, out unchanged; then shift 101 bits then commit -> cfg_err=1 again.
REQ-023 Shift pattern A (100 bits), then 100 more bits with prog_en=1 -> prog_out reproduces A bit-for-bit, delayed 100 cycles.
REQ-024 Assert prog_commit during the 100th shift cycle -> commit rejected, cfg_err=1, counter=1.
REQ-025 Commit config A, then shift config B without commit -> out keeps config A throughout; after commit -> out follows B from the next cycle.
REQ-026 Pulse prog_rst_n low after 50 shifted bits -> out all 0, cfg_valid=0, prog_out=0; a fresh 100-bit frame plus commit is accepted.
